// File: rtl/prog_div_pkg.sv
// Shared definitions for the programmable clock-enable divider:
// FSM state encoding and the smallest legal divisor.
package prog_div_pkg;

  // Controller states; the numeric values are fixed so that
  // waveform viewers and other blocks decode them consistently.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN      = 2'b01,
    RUN_PEND = 2'b10
  } state_e;

  // Smallest divisor that still produces a distinct tick each period.
  // Requests below this are raised to it when they are accepted.
  localparam int unsigned MIN_DIV = 32'd2;

endpackage

// File: rtl/prog_div_counter.sv
// Mod-N up-counter used as the period timer of prog_div_fsm.
// Counts 0..last, wraps to 0 after 'last', and holds when disabled.
// 'clr' takes priority over 'en' and forces the count back to 0.
// 'wrap' is high while the count sits on its terminal value.
module prog_div_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] last,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_r;

  // Period count register: clear, wrap at terminal value, or increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      if (cnt_r == last) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt  = cnt_r;
  assign wrap = (cnt_r == last);

endmodule

// File: rtl/prog_div_fsm.sv
// Runtime-programmable clock-enable divider.
// Emits a one-cycle tick on the last count of every period, and drives
// led either with the tick (mode=0) or with a square wave (mode=1).
// A new divisor is offered through a valid/ready handshake
// (div_load / div_ready). While the block is running, the new divisor
// is held pending and only takes effect at the next period boundary,
// so a period is never cut short.
// Divisors 0 and 1 are raised to 2 when they are accepted.
// Build option: define PROG_DIV_ERR_EN to add the sticky div_err flag,
// which records that an illegal divisor was ever accepted.
module prog_div_fsm
  import prog_div_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_value,
  output logic             div_ready,
  output logic             tick,
  output logic             led
`ifdef PROG_DIV_ERR_EN
  ,
  output logic             div_err
`endif
);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [CNT_W-1:0] div_cur_r;
  logic [CNT_W-1:0] div_pend_r;
  logic             mode_r;

  logic [CNT_W-1:0] cnt_s;
  logic             wrap_s;
  logic [CNT_W-1:0] last_s;
  logic             running_s;
  logic             clr_s;

  logic             accept_s;
  logic             illegal_s;
  logic [CNT_W-1:0] clamped_s;
  logic             load_cur_s;
  logic [CNT_W-1:0] cur_val_s;
  logic             load_pend_s;

  logic             tick_s;
  logic             led_s;
  logic             ready_s;

  // div_cur_r is never below MIN_DIV, so subtracting one cannot underflow.
  assign last_s    = div_cur_r - CNT_W'(1'b1);
  assign running_s = (state_r != IDLE);

  // While idle the count is held at 0. Dropping en also returns the count
  // to 0, so a partial period never produces a tick.
  assign clr_s     = (!running_s) || (!en);

  // A request is taken whenever the block is ready for it.
  // Illegal divisors are raised to MIN_DIV at this point.
  assign accept_s  = div_load && ready_s;
  assign illegal_s = (div_value < CNT_W'(MIN_DIV));
  assign clamped_s = illegal_s ? CNT_W'(MIN_DIV) : div_value;

  prog_div_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_s),
    .en    (running_s),
    .last  (last_s),
    .cnt   (cnt_s),
    .wrap  (wrap_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. It also decides when the active divisor and the
  // pending divisor registers are written.
  always_comb begin
    state_nxt_s = state_r;
    load_cur_s  = 1'b0;
    cur_val_s   = div_cur_r;
    load_pend_s = 1'b0;
    case (state_r)
      IDLE: begin
        // No period is in progress, so a new divisor takes effect at once.
        if (accept_s) begin
          load_cur_s = 1'b1;
          cur_val_s  = clamped_s;
        end else begin
          load_cur_s = 1'b0;
        end
        if (en) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (!en) begin
          // Stopping: a divisor accepted in this same cycle is applied
          // as the block enters IDLE.
          state_nxt_s = IDLE;
          if (accept_s) begin
            load_cur_s = 1'b1;
            cur_val_s  = clamped_s;
          end else begin
            load_cur_s = 1'b0;
          end
        end else if (accept_s) begin
          // Park the request. Even if this cycle is itself a wrap, the
          // new divisor waits for the following wrap.
          load_pend_s = 1'b1;
          state_nxt_s = RUN_PEND;
        end else begin
          state_nxt_s = RUN;
        end
      end
      RUN_PEND: begin
        // The pending divisor is applied at the end of the current period,
        // or immediately if the block is stopped.
        if ((!en) || wrap_s) begin
          load_cur_s = 1'b1;
          cur_val_s  = div_pend_r;
          if (en) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = RUN_PEND;
        end
      end
      default: begin
        // Unused encoding: return to a known safe state.
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Registers for the active divisor, the pending divisor and the
  // led mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cur_r  <= CNT_W'(DEFAULT_DIV);
      div_pend_r <= '0;
      mode_r     <= 1'b0;
    end else begin
      mode_r <= mode;
      if (load_cur_s) begin
        div_cur_r <= cur_val_s;
      end else begin
        div_cur_r <= div_cur_r;
      end
      if (load_pend_s) begin
        div_pend_r <= clamped_s;
      end else begin
        div_pend_r <= div_pend_r;
      end
    end
  end

  // Output decode. It uses only registered state, count, divisor and
  // mode, so no input reaches an output combinationally.
  always_comb begin
    tick_s  = 1'b0;
    led_s   = 1'b0;
    ready_s = 1'b1;
    if (running_s) begin
      tick_s = wrap_s;
    end else begin
      tick_s = 1'b0;
    end
    if (mode_r) begin
      // Square wave: high for the first floor(div/2) counts of each period.
      led_s = running_s && (cnt_s < (div_cur_r >> 1));
    end else begin
      led_s = tick_s;
    end
    if (state_r == RUN_PEND) begin
      ready_s = 1'b0;
    end else begin
      ready_s = 1'b1;
    end
  end

  assign tick      = tick_s;
  assign led       = led_s;
  assign div_ready = ready_s;

`ifdef PROG_DIV_ERR_EN
  logic div_err_r;

  // Sticky flag: set when an illegal divisor is accepted, cleared only
  // by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_err_r <= 1'b0;
    end else if (accept_s && illegal_s) begin
      div_err_r <= 1'b1;
    end else begin
      div_err_r <= div_err_r;
    end
  end

  assign div_err = div_err_r;
`endif

endmodule

// File: tb/tb_prog_div_fsm.sv
// Self-checking bench for prog_div_fsm. Directed scenarios are followed
// by a randomized run. Every cycle the DUT outputs are compared against
// a behavioural model of the divider kept here: a running flag, the
// position within the period, the period length and a queue of waiting
// divisors.
module tb_prog_div_fsm;

  localparam int CNT_W = 8;
  localparam int DEF   = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             mode;
  logic             div_load;
  logic [CNT_W-1:0] div_value;
  logic             div_ready;
  logic             tick;
  logic             led;
`ifdef PROG_DIV_ERR_EN
  logic             div_err;
`endif

  int tests = 0;
  int fails = 0;

  // Behavioural model state.
  bit m_run;
  int m_ph;
  int m_per;
  int m_pend[$];
  bit m_md;
  bit m_err;

  prog_div_fsm #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .div_load  (div_load),
    .div_value (div_value),
    .div_ready (div_ready),
    .tick      (tick),
    .led       (led)
`ifdef PROG_DIV_ERR_EN
    ,
    .div_err   (div_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge, using the inputs driven
  // before that edge.
  task automatic model_step(input bit r, input bit e, input bit m, input bit ld, input int v);
    bit accept;
    int cv;
    if (r) begin
      m_run = 1'b0;
      m_ph  = 0;
      m_per = DEF;
      m_pend.delete();
      m_md  = 1'b0;
      m_err = 1'b0;
    end else begin
      accept = ld && (m_pend.size() == 0);
      cv     = (v < 2) ? 2 : v;
      if (accept && (v < 2)) m_err = 1'b1;
      m_md = m;
      if (!m_run) begin
        if (accept) m_per = cv;
        m_run = e;
        m_ph  = 0;
      end else if (!e) begin
        if (m_pend.size() > 0) m_per = m_pend.pop_front();
        else if (accept) m_per = cv;
        m_run = 1'b0;
        m_ph  = 0;
      end else begin
        if (m_ph == m_per - 1) begin
          m_ph = 0;
          if (m_pend.size() > 0) m_per = m_pend.pop_front();
        end else begin
          m_ph = m_ph + 1;
        end
        if (accept) m_pend.push_back(cv);
      end
    end
  endtask

  task automatic check_all(input string tag);
    bit et;
    bit el;
    et = m_run && (m_ph == m_per - 1);
    el = m_md ? (m_run && (m_ph < m_per / 2)) : et;
    chk({tag, ".tick"}, tick, et);
    chk({tag, ".led"}, led, el);
    chk({tag, ".ready"}, div_ready, (m_pend.size() == 0));
`ifdef PROG_DIV_ERR_EN
    chk({tag, ".err"}, div_err, m_err);
`endif
  endtask

  // Drive one cycle of inputs, let the clock edge pass, then check the
  // outputs half a period later.
  task automatic cycle(input string tag, input bit r, input bit e, input bit m,
                       input bit ld, input int v);
    reset     = r;
    en        = e;
    mode      = m;
    div_load  = ld;
    div_value = CNT_W'(v);
    model_step(r, e, m, ld, v);
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    bit r;
    bit e;
    bit md;
    bit ld;
    int v;
    reset = 1'b1; en = 1'b0; mode = 1'b0; div_load = 1'b0; div_value = '0;
    m_run = 1'b0; m_ph = 0; m_per = DEF; m_md = 1'b0; m_err = 1'b0;
    @(negedge clk);

    // 1: reset values, then pulse mode with the default divisor.
    cycle("rst", 1'b1, 1'b0, 1'b0, 1'b0, 0);
    cycle("rst", 1'b1, 1'b1, 1'b1, 1'b1, 9);
    chk("rst.tick0", tick, 1'b0);
    chk("rst.led0", led, 1'b0);
    chk("rst.ready1", div_ready, 1'b1);
    for (int i = 0; i < 14; i++) cycle("t1", 1'b0, 1'b1, 1'b0, 1'b0, 0);

    // 2: square wave with divisors 5 and 4.
    cycle("t2", 1'b0, 1'b1, 1'b1, 1'b1, 5);
    for (int i = 0; i < 16; i++) cycle("t2", 1'b0, 1'b1, 1'b1, 1'b0, 0);
    cycle("t2", 1'b0, 1'b1, 1'b1, 1'b1, 4);
    for (int i = 0; i < 12; i++) cycle("t2", 1'b0, 1'b1, 1'b1, 1'b0, 0);

    // 3: load 6 at count 1 with divisor 4; not ready until the wrap.
    for (int k = 0; k < 20 && !(m_run && m_ph == 1); k++) cycle("t3w", 1'b0, 1'b1, 1'b0, 1'b0, 0);
    cycle("t3", 1'b0, 1'b1, 1'b0, 1'b1, 6);
    chk("t3.busy", div_ready, 1'b0);
    for (int i = 0; i < 14; i++) cycle("t3", 1'b0, 1'b1, 1'b0, 1'b0, 0);

    // 4: illegal divisor 0 is raised to 2.
    cycle("t4", 1'b0, 1'b1, 1'b0, 1'b1, 0);
    for (int i = 0; i < 14; i++) cycle("t4", 1'b0, 1'b1, 1'b0, 1'b0, 0);

    // 5: stop at count 2 while divisor 7 is pending, then re-enable.
    cycle("t5", 1'b0, 1'b1, 1'b0, 1'b1, 5);
    for (int i = 0; i < 10; i++) cycle("t5", 1'b0, 1'b1, 1'b0, 1'b0, 0);
    cycle("t5", 1'b0, 1'b1, 1'b0, 1'b1, 7);
    for (int k = 0; k < 20 && !(m_run && m_ph == 2 && m_pend.size() > 0); k++)
      cycle("t5w", 1'b0, 1'b1, 1'b0, 1'b0, 0);
    cycle("t5", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("t5.idle_ready", div_ready, 1'b1);
    chk("t5.idle_tick", tick, 1'b0);
    for (int i = 0; i < 2; i++) cycle("t5", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 16; i++) cycle("t5", 1'b0, 1'b1, 1'b0, 1'b0, 0);

    // 6: reset in the middle of a period while a load is pending.
    cycle("t6", 1'b0, 1'b1, 1'b0, 1'b1, 9);
    cycle("t6", 1'b0, 1'b1, 1'b0, 1'b0, 0);
    cycle("t6", 1'b1, 1'b1, 1'b0, 1'b0, 0);
    chk("t6.rst_ready", div_ready, 1'b1);
    for (int i = 0; i < 12; i++) cycle("t6", 1'b0, 1'b1, 1'b0, 1'b0, 0);

    // Randomized run.
    md = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      e  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) md = ~md;
      ld = ($urandom_range(0, 7) == 0);
      v  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 40)) : int'($urandom_range(0, 9));
      cycle("rnd", r, e, md, ld, v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
